// File: rtl/accum_result_fifo.sv
// accum_result_fifo: capture stage behind the 8-bit signed add/subtract
// accumulator. Valid results {sum, carry, ovf} are queued in a small
// first-word-fall-through FIFO and drained through a valid/ready port.
// Saturating counters track overflow events and samples dropped while full.
//
// Optional build macro: ACC_RESULT_SAT_EN
//   defined   -> results tagged with overflow are stored saturated
//                (+max when the wrapped sum looks negative, -min otherwise)
//   undefined -> the wrapped sum is stored raw, only the ovf tag marks it
module accum_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [W-1:0]               i_sum,
  input  logic                       i_carry,
  input  logic                       i_ovf,
  input  logic                       i_clr,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [W-1:0]               o_data,
  output logic                       o_data_carry,
  output logic                       o_data_ovf,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_W-1:0]           o_ovf_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt,
  output logic                       o_ovf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = W + 2;  // {sum, carry, ovf}
  localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0]     SAT_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     SAT_NEG   = {1'b1, {(W-1){1'b0}}};

  // Registered state
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [CNT_W-1:0] ovf_cnt_reg, ovf_cnt_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic             sticky_reg, sticky_next;
  logic [EW-1:0]    entry_mem [DEPTH];

  // Handshake decode
  logic             empty_now;
  logic             full_now;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ovf_event;
  logic [W-1:0]     store_sum;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head_entry;
  logic [CNT_W-1:0] ovf_base;
  logic [CNT_W-1:0] drop_base;
  logic [DEPTH-1:0] wr_sel;

  assign empty_now = (count_reg == '0);
  assign full_now  = (count_reg == DEPTH_CNT);
  // A pop needs a registered head; ready while empty is ignored, so a
  // push into an empty FIFO never bypasses to the output in the same cycle.
  assign pop       = !empty_now && i_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push      = i_valid && (!full_now || pop);
  assign drop      = i_valid && full_now && !pop;
  assign ovf_event = i_valid && i_ovf;

`ifdef ACC_RESULT_SAT_EN
  // Overflow flips the sign bit, so a negative-looking wrapped sum came
  // from a positive overflow and saturates to +max, and vice versa.
  assign store_sum = i_ovf ? (i_sum[W-1] ? SAT_POS : SAT_NEG) : i_sum;
`else
  assign store_sum = i_sum;
`endif

  assign wr_entry = {store_sum, i_carry, i_ovf};

  // Next-state for pointers, occupancy and the event counters
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    ovf_base      = i_clr ? '0 : ovf_cnt_reg;
    drop_base     = i_clr ? '0 : drop_cnt_reg;
    ovf_cnt_next  = ovf_base;
    drop_cnt_next = drop_base;
    sticky_next   = i_clr ? 1'b0 : sticky_reg;

    // Pointers are power-of-two wide, so increment wraps DEPTH-1 -> 0.
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);

    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase

    // Clear takes effect first, then this cycle's event is counted.
    if (ovf_event) begin
      sticky_next = 1'b1;
      if (ovf_base != CNT_MAX) ovf_cnt_next = ovf_base + CNT_W'(1);
    end
    if (drop && (drop_base != CNT_MAX)) begin
      drop_cnt_next = drop_base + CNT_W'(1);
    end
  end

  // Control state register; reset discards all queued entries
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ovf_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      sticky_reg   <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      ovf_cnt_reg  <= ovf_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      sticky_reg   <= sticky_next;
    end
  end

  // Storage: one write-enabled register per slot. Contents need no reset;
  // the output is masked while empty and a slot is always written before
  // it becomes the head.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign wr_sel[gi] = push && (wr_ptr_reg == AW'(gi));

      // Capture the incoming result when this slot is the write target
      always_ff @(posedge i_clk) begin
        if (!i_rst && wr_sel[gi]) begin
          entry_mem[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  // First-word fall-through head, decoded from registered state only
  assign head_entry   = entry_mem[rd_ptr_reg];
  assign o_valid      = !empty_now;
  assign o_data       = empty_now ? '0   : head_entry[EW-1:2];
  assign o_data_carry = empty_now ? 1'b0 : head_entry[1];
  assign o_data_ovf   = empty_now ? 1'b0 : head_entry[0];
  assign o_count      = count_reg;
  assign o_full       = full_now;
  assign o_empty      = empty_now;
  assign o_ovf_cnt    = ovf_cnt_reg;
  assign o_drop_cnt   = drop_cnt_reg;
  assign o_ovf_sticky = sticky_reg;

endmodule

// File: tb/tb_accum_result_fifo.sv
// tb_accum_result_fifo: directed stimulus with a scoreboard queue. The
// stimulus pushes the expected head entry when it issues an accepted sample;
// a negedge monitor pops and compares whenever the reader takes an entry.
// Honours ACC_RESULT_SAT_EN the same way the design does.
module tb_accum_result_fifo;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_sum;
  logic       i_carry;
  logic       i_ovf;
  logic       i_clr;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_data_carry;
  logic       o_data_ovf;
  logic [3:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic [7:0] o_ovf_cnt;
  logic [7:0] o_drop_cnt;
  logic       o_ovf_sticky;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q [$];

  accum_result_fifo #(.W(8), .DEPTH(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_sum(i_sum),
    .i_carry(i_carry), .i_ovf(i_ovf), .i_clr(i_clr), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_data_carry(o_data_carry),
    .o_data_ovf(o_data_ovf), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty), .o_ovf_cnt(o_ovf_cnt), .o_drop_cnt(o_drop_cnt),
    .o_ovf_sticky(o_ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected stored value for a given sample
  function automatic logic [7:0] stored(input logic [7:0] s, input logic v);
`ifdef ACC_RESULT_SAT_EN
    if (v) return s[7] ? 8'h7F : 8'h80;
`endif
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample for one cycle; accepted samples go to the scoreboard
  task automatic push(input logic [7:0] s, input logic c, input logic v, input bit accept);
    i_valid = 1'b1;
    i_sum   = s;
    i_carry = c;
    i_ovf   = v;
    if (accept) exp_q.push_back({stored(s, v), c, v});
    step();
    i_valid = 1'b0;
    i_carry = 1'b0;
    i_ovf   = 1'b0;
  endtask

  task automatic drain(input int n);
    i_ready = 1'b1;
    repeat (n) step();
    i_ready = 1'b0;
    chk("drain_empty", o_empty, 1);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  // Monitor: a transfer happens at the next edge when valid && ready
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL pop_unexpected: got %0h, expected no entry", o_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({o_data, o_data_carry, o_data_ovf} !== e) begin
          fails++;
          $display("[TB] FAIL pop_entry: got data=%0h c=%0b v=%0b, expected data=%0h c=%0b v=%0b",
                   o_data, o_data_carry, o_data_ovf, e[9:2], e[1], e[0]);
        end else begin
          $display("[TB] pop data=%0h carry=%0b ovf=%0b ok", o_data, o_data_carry, o_data_ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_sum = '0; i_carry = 1'b0;
    i_ovf = 1'b0; i_clr = 1'b0; i_ready = 1'b0;
    step(); step();
    i_rst = 1'b0;

    // Reset state
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ovf_cnt", o_ovf_cnt, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_sticky", o_ovf_sticky, 0);

    // Ordered push then drain: 17, 92, 29, -7
    push(8'd17, 1'b0, 1'b0, 1);
    chk("latency_valid", o_valid, 1);
    push(8'd92, 1'b0, 1'b0, 1);
    push(8'd29, 1'b1, 1'b0, 1);
    push(8'hF9, 1'b0, 1'b0, 1);   // -7
    chk("four_count", o_count, 4);
    drain(4);

    // Positive overflow: 93 then 93+93 wraps to -70
    push(8'd93, 1'b0, 1'b0, 1);
    push(8'hBA, 1'b0, 1'b1, 1);   // -70, ovf
    chk("posovf_cnt", o_ovf_cnt, 1);
    chk("posovf_sticky", o_ovf_sticky, 1);
    drain(2);

    // Negative overflow: -111 then -111-37 wraps to 108 with carry
    push(8'h91, 1'b0, 1'b0, 1);   // -111
    push(8'h6C, 1'b1, 1'b1, 1);   // 108, ovf
    chk("negovf_cnt", o_ovf_cnt, 2);
    drain(2);

    // Fill to full, then three pushes dropped (one of them an overflow)
    for (int k = 1; k <= 8; k++) push(8'(k), 1'b0, 1'b0, 1);
    chk("fill_full", o_full, 1);
    chk("fill_count", o_count, 8);
    push(8'd100, 1'b0, 1'b0, 0);
    push(8'd101, 1'b0, 1'b1, 0);
    push(8'd102, 1'b0, 1'b0, 0);
    chk("drop_cnt3", o_drop_cnt, 3);
    chk("drop_ovf_cnt", o_ovf_cnt, 3);
    chk("drop_head", o_data, 1);
    chk("drop_full", o_full, 1);

    // Full with simultaneous push and pop
    i_ready = 1'b1;
    push(8'd9, 1'b0, 1'b0, 1);
    i_ready = 1'b0;
    chk("fullpp_count", o_count, 8);
    chk("fullpp_drop", o_drop_cnt, 3);
    chk("fullpp_head", o_data, 2);
    drain(8);

    // Clear alone: counters and sticky zero, entries kept
    push(8'd11, 1'b0, 1'b0, 1);
    push(8'd12, 1'b0, 1'b1, 1);
    chk("preclr_ovf_cnt", o_ovf_cnt, 4);
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("clr_ovf_cnt", o_ovf_cnt, 0);
    chk("clr_drop_cnt", o_drop_cnt, 0);
    chk("clr_sticky", o_ovf_sticky, 0);
    chk("clr_count", o_count, 2);
    drain(2);

    // Empty with push and ready together: no bypass
    i_ready = 1'b1;
    i_valid = 1'b1; i_sum = 8'd55; i_carry = 1'b0; i_ovf = 1'b0;
    chk("bypass_valid", o_valid, 0);
    exp_q.push_back({8'd55, 1'b0, 1'b0});
    step();
    i_valid = 1'b0;
    chk("bypass_count", o_count, 1);
    step();
    i_ready = 1'b0;
    chk("bypass_drained", o_count, 0);

    // Clear and overflow event in the same cycle
    i_clr = 1'b1;
    push(8'd5, 1'b0, 1'b1, 1);
    i_clr = 1'b0;
    chk("clrev_ovf_cnt", o_ovf_cnt, 1);
    chk("clrev_sticky", o_ovf_sticky, 1);
    chk("clrev_drop", o_drop_cnt, 0);
    chk("clrev_head", o_data, stored(8'd5, 1'b1));

    // Reset mid-operation with 5 entries and two overflow events
    push(8'd20, 1'b0, 1'b0, 1);
    push(8'd21, 1'b0, 1'b1, 1);
    push(8'd22, 1'b0, 1'b0, 1);
    push(8'd23, 1'b0, 1'b0, 1);
    chk("mid_count", o_count, 5);
    chk("mid_ovf_cnt", o_ovf_cnt, 2);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_q.delete();
    chk("mrst_count", o_count, 0);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_data", o_data, 0);
    chk("mrst_ovf_cnt", o_ovf_cnt, 0);
    chk("mrst_sticky", o_ovf_sticky, 0);

    // Counter saturation: fill, then 260 dropped overflow samples
    for (int k = 0; k < 8; k++) push(8'(k + 40), 1'b0, 1'b0, 1);
    for (int k = 0; k < 260; k++) push(8'd1, 1'b0, 1'b1, 0);
    chk("sat_drop_cnt", o_drop_cnt, 255);
    chk("sat_ovf_cnt", o_ovf_cnt, 255);
    chk("sat_head", o_data, 40);
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
